// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder sequencer.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_DATA_WIDTH = 8;

  // Counter must be able to hold the value DATA_WIDTH itself.
  function automatic int cnt_width(input int data_width);
    return $clog2(data_width + 1);
  endfunction

endpackage

// File: rtl/bit_down_counter.sv
// Loadable down counter that saturates at zero; flags the last count.
module bit_down_counter #(
  parameter int CNT_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 is_one
);

  logic [CNT_WIDTH-1:0] count_q;

  always_ff @(posedge i_clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == CNT_WIDTH'(1));

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for the bit-serial adder: captures an operand pair, ripples one
// full-add per cycle LSB-first, then holds sum/carry-out until consumed.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CNT_WIDTH  = cnt_width(DATA_WIDTH)
) (
  input  logic                  i_clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a_in,
  input  logic [DATA_WIDTH-1:0] b_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic                  cout_out,
  output logic                  busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; ready/valid here depend on registered state only.

  state_e                state_q;
  logic [DATA_WIDTH-1:0] a_sr_q;
  logic [DATA_WIDTH-1:0] b_sr_q;
  logic [DATA_WIDTH-1:0] sum_sr_q;
  logic                  carry_q;

  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  cnt_is_one;
  logic                  cnt_load;
  logic                  cnt_en;
  logic                  bit_s;
  logic                  bit_c;

  assign bit_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

  assign cnt_load = (state_q == IDLE) && in_valid;
  assign cnt_en   = (state_q == RUN) && (cnt_q != '0);

  bit_down_counter #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt (
    .i_clk   (i_clk),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(CNT_WIDTH'(DATA_WIDTH)),
    .en      (cnt_en),
    .count   (cnt_q),
    .is_one  (cnt_is_one)
  );

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sr_q   <= a_in;
            b_sr_q   <= b_in;
            sum_sr_q <= '0;
            carry_q  <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          sum_sr_q <= {bit_s, sum_sr_q[DATA_WIDTH-1:1]};
          carry_q  <= bit_c;
          a_sr_q   <= {1'b0, a_sr_q[DATA_WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[DATA_WIDTH-1:1]};
          // The counter still holds 1 while the final bit is being added.
          if (cnt_is_one) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign sum_out   = sum_sr_q;
  assign cout_out  = carry_q;

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Sequencer for the bit-serial adder. It accepts a pair of DATA_WIDTH-bit operands over a valid/ready handshake and steps the Mealy carry stage LSB-first for exactly DATA_WIDTH cycles, using a loadable down bit-counter as its cycle count. It then presents sum and carry-out over a second valid/ready handshake. It sits between the operand source and the result consumer and is the only block that enables or clears the bit counter and the carry flop.

## Interface
- DATA_WIDTH, 8: operand and sum width; legal range 2..32.
- CNT_WIDTH, $clog2(DATA_WIDTH+1): bit-counter width; must hold the value DATA_WIDTH.
- i_clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands; high only in IDLE.
- a_in  in  DATA_WIDTH  operand A.
- b_in  in  DATA_WIDTH  operand B.
- out_valid  out  1  sum_out and cout_out valid; high only in DONE.
- out_ready  in  1  consumer accepts the result.
- sum_out  out  DATA_WIDTH  A+B modulo 2^DATA_WIDTH.
- cout_out  out  1  carry out of the MSB.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- Registered state: a_sr, b_sr, sum_sr, carry, cnt, and the state.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: a_sr←a_in, b_sr←b_in, sum_sr←0, carry←0, cnt←DATA_WIDTH, state→RUN.
- RUN, every cycle:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry ← majority(a_sr[0], b_sr[0], carry).
  - sum_sr ← {s, sum_sr[DATA_WIDTH-1:1]}.
  - a_sr and b_sr shift right, zero-filled.
  - cnt ← cnt−1.
- RUN exit: when cnt==1 at the edge, the current bit is the last one; state→DONE.
- RUN ignores in_valid (in_ready=0). Operands are not captured and no error is raised.
- DONE:
  - out_valid=1; sum_out=sum_sr, cout_out=carry.
  - Outputs are held stable while out_ready=0.
  - On out_ready at an edge: state→IDLE. sum_sr and carry keep their values; out_valid drops.
- in_valid is not a sticky request: if the source holds it high across DONE, acceptance happens in the next IDLE cycle.
- Arithmetic is an unsigned ripple of 1-bit full adds. cnt never wraps: it is loaded only in IDLE and decremented only in RUN while nonzero.
- Reset (any state, including mid-RUN or DONE):
  - state=IDLE; cnt=0, carry=0, sum_sr=0, a_sr=b_sr=0.
  - Any operation in flight is discarded with no result.
- Reset values of outputs: in_ready=1, out_valid=0, busy=0, sum_out=0, cout_out=0.
- Reset has priority over every handshake in the same cycle.

## Timing
- Acceptance edge t0.
- RUN occupies the cycles ending at edges t1..tDATA_WIDTH.
- out_valid rises after edge tDATA_WIDTH, i.e. DATA_WIDTH cycles after acceptance.
- With out_ready tied high, DONE lasts 1 cycle and IDLE at least 1 cycle.
- Minimum initiation interval: DATA_WIDTH+2 cycles (10 for the default).
- in_ready, out_valid and busy are decoded from the registered state only. There is no combinational path from in_valid or out_ready to any output.
- sum_out and cout_out are driven directly from registers.

## Structure
- Package serial_add_pkg holds:
  - State enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - Default DATA_WIDTH.
  - CNT_WIDTH derivation function.
- Sub-module bit_down_counter (i_clk, reset, load, load_val, en, count, is_one):
  - reset→0.
  - load has priority over en.
  - en decrements, saturating at 0.
  - is_one = (count==1).
- The controller instantiates one bit_down_counter and keeps the shift registers, the carry flop and the FSM itself.

## Test plan
- 0x5A + 0x3C, out_ready=1 → out_valid exactly 8 cycles after acceptance; sum_out=0x96, cout_out=0.
- 0xFF + 0x01 → sum_out=0x00, cout_out=1. Then 0x00 + 0x00 → sum_out=0x00, cout_out=0, which checks that carry is cleared between operations.
- 0x80 + 0x80 with out_ready=0 for 5 cycles → out_valid held; sum_out=0x00 and cout_out=1 stable throughout; IDLE is reached one edge after out_ready=1.
- in_valid pulsed with 0x11/0x22 during RUN of 0x01 + 0x02 → result 0x03 only, and no second out_valid.
- reset asserted on the 4th RUN cycle of 0xAA + 0x55 → next cycle: IDLE, out_valid=0, in_ready=1, sum_out=0. A following 0x0F + 0x01 gives 0x10, cout_out=0.
- in_valid and out_ready held high for back-to-back operands 0x01 + 0x01, 0x7F + 0x01 → results 0x02 then 0x80, with the two out_valid pulses 10 cycles apart.
